cache_fill_controller: RTL and testbench

Miss-handling controller that owns the single main-memory port shared by the instruction cache, the data cache and write-through stores. On a cache miss it fetches the 8-word (16-byte) block from pipelined memory, streams each returned word into the missing cache's data array, then writes the tag/valid/LRU entry. It sits between the two caches and main memory and drives the pipeline-wide stall.

---
 rtl/cache_fill_controller_pkg.sv | 35 +++
 rtl/cache_fill_controller_if.sv | 58 +++++
 rtl/cache_fill_controller_counter.sv | 32 +++
 rtl/cache_fill_controller.sv | 119 +++++++++++
 tb/tb_cache_fill_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_controller_pkg.sv
// cache_ctrl_pkg: shared types and constants for the cache fill controller.
//   state_t         - controller FSM states
//   WORDS_PER_BLOCK - 16-bit words fetched per block fill (power of 2)
//   BLOCK_BYTES     - bytes per block
//   OFFSET_BITS     - byte-offset bits inside a block
//   CNT_W           - counter width; one extra bit so WORDS_PER_BLOCK fits
//   block_base()    - clears the offset bits of a byte address
//   word_addr()     - byte address of word <idx> inside a block
package cache_ctrl_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_BYTES     = 2 * WORDS_PER_BLOCK;
  localparam int OFFSET_BITS     = 4;
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    FILL  = 2'd2,
    TAG   = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  // Word index scaled to a byte offset; the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + {{(ADDR_W-CNT_W-1){1'b0}}, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_controller_if.sv
// cache_fill_controller_if: all non-clock signals between the fill controller,
// the two caches, the store path and main memory.
//   Requests:  icache_miss/addr, dcache_miss/addr, store_req/addr/data
//   Memory:    mem_addr, mem_enable, mem_wr, mem_wdata, mem_data_valid, mem_data_out
//   Fill:      fill_data, fill_addr, {i,d}cache_write_data_array, {i,d}cache_write_tag_array
//   Control:   store_ack, stall, dbg_state (controller FSM state for observation)
// Handshakes: icache_miss/dcache_miss are levels held by the cache until its
// tag write has happened; store_req is a level held until the single-cycle
// store_ack pulse, after which the requester drops it. Memory accepts one
// access on every cycle mem_enable is high and never back-pressures; read data
// comes back on mem_data_valid a fixed latency later, in issue order.
interface cache_fill_controller_if;
  import cache_ctrl_pkg::*;

  logic              icache_miss;
  logic [ADDR_W-1:0] icache_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_addr;
  logic              store_req;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data_out;

  logic [DATA_W-1:0] fill_data;
  logic [ADDR_W-1:0] fill_addr;
  logic              icache_write_data_array;
  logic              dcache_write_data_array;
  logic              icache_write_tag_array;
  logic              dcache_write_tag_array;
  logic              store_ack;
  logic              stall;
  state_t            dbg_state;

  modport master (
    input  icache_miss, icache_addr, dcache_miss, dcache_addr,
           store_req, store_addr, store_data, mem_data_valid, mem_data_out,
    output mem_addr, mem_enable, mem_wr, mem_wdata, fill_data, fill_addr,
           icache_write_data_array, dcache_write_data_array,
           icache_write_tag_array, dcache_write_tag_array,
           store_ack, stall, dbg_state
  );

  modport slave (
    output icache_miss, icache_addr, dcache_miss, dcache_addr,
           store_req, store_addr, store_data, mem_data_valid, mem_data_out,
    input  mem_addr, mem_enable, mem_wr, mem_wdata, fill_data, fill_addr,
           icache_write_data_array, dcache_write_data_array,
           icache_write_tag_array, dcache_write_tag_array,
           store_ack, stall, dbg_state
  );

endinterface

// File: rtl/cache_fill_controller_counter.sv
// fill_word_counter: loadable up-counter used for the fill issue and return
// word counts.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear (highest priority after reset)
//   load      - synchronous load of load_val
//   en        - increment by one
//   count     - current value
//   done      - count equals TERMINAL
module fill_word_counter #(
  parameter int W        = 4,
  parameter int TERMINAL = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + W'(1);
  end

  assign done = (count == W'(TERMINAL));

endmodule

// File: rtl/cache_fill_controller.sv
// cache_fill_controller: owns the single memory port. Arbitrates between
// write-through stores and I/D cache misses, fetches a whole block for a miss
// with one read issued per cycle, streams returned words into the missing
// cache's data array, then strobes its tag array once.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - cache_fill_controller_if.master (requests, memory port,
//              fill strobes, store_ack, stall, dbg_state)
module cache_fill_controller
  import cache_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  cache_fill_controller_if.master       bus
);

  state_t            state_q, state_d;
  logic              sel_d_q;          // 1: filling the D-cache, 0: the I-cache
  logic [ADDR_W-1:0] base_q;
  logic              start_fill;
  logic [CNT_W-1:0]  issue_cnt, ret_cnt;
  logic              issue_done, ret_last;
  logic              issue_en, ret_en;

  // Reads are issued until all words of the block are out; returns are
  // counted independently because memory is pipelined.
  assign issue_en = (state_q == FILL) && !issue_done;
  assign ret_en   = (state_q == FILL) && bus.mem_data_valid;

  fill_word_counter #(.W(CNT_W), .TERMINAL(WORDS_PER_BLOCK)) u_issue_cnt (
    .clk(clk), .rst(rst), .clr(start_fill), .load(1'b0), .load_val('0),
    .en(issue_en), .count(issue_cnt), .done(issue_done)
  );

  // Terminal flag marks the last returning word, which ends the fill.
  fill_word_counter #(.W(CNT_W), .TERMINAL(WORDS_PER_BLOCK - 1)) u_ret_cnt (
    .clk(clk), .rst(rst), .clr(start_fill), .load(1'b0), .load_val('0),
    .en(ret_en), .count(ret_cnt), .done(ret_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_d_q <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_fill) begin
        // D wins a simultaneous miss; the I miss stays asserted and is
        // picked up in the IDLE cycle after this fill.
        sel_d_q <= bus.dcache_miss;
        base_q  <= block_base(bus.dcache_miss ? bus.dcache_addr : bus.icache_addr);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.store_req) begin
          state_d = STORE;
        end else if (bus.dcache_miss || bus.icache_miss) begin
          state_d    = FILL;
          start_fill = 1'b1;
        end
      end
      STORE: state_d = IDLE;
      FILL:  if (ret_en && ret_last) state_d = TAG;
      TAG:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_enable              = 1'b0;
    bus.mem_wr                  = 1'b0;
    bus.mem_addr                = '0;
    bus.mem_wdata               = '0;
    bus.store_ack               = 1'b0;
    bus.fill_addr               = '0;
    bus.icache_write_data_array = 1'b0;
    bus.dcache_write_data_array = 1'b0;
    bus.icache_write_tag_array  = 1'b0;
    bus.dcache_write_tag_array  = 1'b0;
    unique case (state_q)
      IDLE: ;
      STORE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = bus.store_addr;
        bus.mem_wdata  = bus.store_data;
        bus.store_ack  = 1'b1;
      end
      FILL: begin
        if (!issue_done) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = word_addr(base_q, issue_cnt);
        end
        if (bus.mem_data_valid) begin
          bus.fill_addr               = word_addr(base_q, ret_cnt);
          bus.dcache_write_data_array = sel_d_q;
          bus.icache_write_data_array = !sel_d_q;
        end
      end
      TAG: begin
        bus.fill_addr              = base_q;
        bus.dcache_write_tag_array = sel_d_q;
        bus.icache_write_tag_array = !sel_d_q;
      end
      default: ;
    endcase
  end

  assign bus.fill_data = bus.mem_data_out;
  assign bus.stall     = bus.icache_miss | bus.dcache_miss | bus.store_req | (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cache_fill_controller.sv
// Bench for cache_fill_controller: directed scenarios with a pipelined memory
// model; every output event (memory access, data/tag strobe) is compared with
// an expected queue, tagged with the cycle it must appear in.
module tb_cache_fill_controller;
  import cache_ctrl_pkg::*;

  localparam int LAT = 4;
  localparam int EW  = 51;   // {kind[2:0], cycle[15:0], addr[15:0], data[15:0]}
  localparam logic [2:0] K_RD = 3'd1, K_ST = 3'd2, K_DW = 3'd3, K_IW = 3'd4,
                         K_DT = 3'd5, K_IT = 3'd6, K_BAD = 3'd7;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  cache_fill_controller_if bus();
  cache_fill_controller dut (.clk(clk), .rst(rst), .bus(bus));

  // memory model: read issued in cycle k returns in cycle k+LAT with
  // data {addr[15:4], 0, addr[3:1]}
  logic [LAT-1:0] vld_pipe;
  logic [15:0]    adr_pipe [LAT];
  logic           spurious = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < LAT; i++) adr_pipe[i] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[LAT-2:0], bus.mem_enable & ~bus.mem_wr};
      adr_pipe[0] <= bus.mem_addr;
      for (int i = 1; i < LAT; i++) adr_pipe[i] <= adr_pipe[i-1];
    end
  end

  always_comb begin
    bus.mem_data_valid = vld_pipe[LAT-1] | spurious;
    if (spurious)             bus.mem_data_out = 16'hDEAD;
    else if (vld_pipe[LAT-1]) bus.mem_data_out = {adr_pipe[LAT-1][15:4], 1'b0, adr_pipe[LAT-1][3:1]};
    else                      bus.mem_data_out = 16'h0000;
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [EW-1:0] ev(input logic [2:0] k, input logic [15:0] c,
                                       input logic [15:0] a, input logic [15:0] d);
    return {k, c, a, d};
  endfunction

  // Expected events of the first ncyc FILL/TAG cycles, FILL starting at c0:
  // read k in FILL cycle k, data write k in cycle k+4, tag write in cycle 12.
  task automatic push_fill(input logic is_d, input logic [15:0] base,
                           input logic [15:0] c0, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (c < 8)
        exp_q.push_back(ev(K_RD, c0 + 16'(c), base + 16'(2*c), 16'h0));
      if (c >= 4 && c < 12)
        exp_q.push_back(ev(is_d ? K_DW : K_IW, c0 + 16'(c), base + 16'(2*(c-4)), base + 16'(c-4)));
      if (c == 12)
        exp_q.push_back(ev(is_d ? K_DT : K_IT, c0 + 16'(c), base, 16'h0));
    end
  endtask

  task automatic observe(input logic [2:0] k, input logic [15:0] a, input logic [15:0] d);
    logic [EW-1:0] want;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind=%0d cycle=%0d addr=%h data=%h, expected none", k, cyc, a, d);
    end else begin
      want = exp_q.pop_front();
      check("event", 64'({k, cyc, a, d}), 64'(want));
    end
  endtask

  // monitor: fixed order within a cycle -- memory access, data strobes, tag strobes
  always @(negedge clk) begin
    if (bus.mem_enable || bus.store_ack) begin
      if (bus.mem_enable && !bus.mem_wr && !bus.store_ack) observe(K_RD, bus.mem_addr, 16'h0);
      else if (bus.mem_enable && bus.mem_wr && bus.store_ack) observe(K_ST, bus.mem_addr, bus.mem_wdata);
      else observe(K_BAD, bus.mem_addr, bus.mem_wdata);
    end
    if (bus.dcache_write_data_array) observe(K_DW, bus.fill_addr, bus.fill_data);
    if (bus.icache_write_data_array) observe(K_IW, bus.fill_addr, bus.fill_data);
    if (bus.dcache_write_tag_array)  observe(K_DT, bus.fill_addr, 16'h0);
    if (bus.icache_write_tag_array)  observe(K_IT, bus.fill_addr, 16'h0);
  end

  function automatic logic [63:0] outs();
    return 64'({bus.mem_enable, bus.mem_wr, bus.store_ack,
                bus.dcache_write_data_array, bus.icache_write_data_array,
                bus.dcache_write_tag_array, bus.icache_write_tag_array,
                bus.mem_addr, bus.fill_addr, bus.mem_wdata});
  endfunction

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input logic is_d, input logic [15:0] addr, input logic [15:0] base);
    logic [15:0] n;
    next_cycle();
    n = cyc;
    if (is_d) begin bus.dcache_addr = addr; bus.dcache_miss = 1'b1; end
    else      begin bus.icache_addr = addr; bus.icache_miss = 1'b1; end
    push_fill(is_d, base, n + 16'd1, 13);
    #1 check("stall_on_miss", 64'(bus.stall), 64'd1);
    next_cycle();
    check("state_fill", 64'(bus.dbg_state), 64'(FILL));
    repeat (12) next_cycle();
    check("state_tag", 64'(bus.dbg_state), 64'(TAG));
    next_cycle();
    bus.dcache_miss = 1'b0;
    bus.icache_miss = 1'b0;
    #1;
    check("state_idle_after_fill", 64'(bus.dbg_state), 64'(IDLE));
    check("stall_released", 64'(bus.stall), 64'd0);
  endtask

  logic [15:0] n;

  initial begin
    bus.icache_miss = 1'b0; bus.icache_addr = '0;
    bus.dcache_miss = 1'b0; bus.dcache_addr = '0;
    bus.store_req   = 1'b0; bus.store_addr  = '0; bus.store_data = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 64'd0);
    check("reset_state", 64'(bus.dbg_state), 64'(IDLE));
    check("reset_stall", 64'(bus.stall), 64'd0);
    rst = 1'b0;
    next_cycle();
    check("idle_outputs", outs(), 64'd0);

    // D miss, 0x1236 -> block 0x1230
    run_fill(1'b1, 16'h1236, 16'h1230);

    // simultaneous I and D miss: D block first, then I block
    next_cycle();
    n = cyc;
    bus.dcache_addr = 16'h8000; bus.dcache_miss = 1'b1;
    bus.icache_addr = 16'h0040; bus.icache_miss = 1'b1;
    push_fill(1'b1, 16'h8000, n + 16'd1, 13);
    push_fill(1'b0, 16'h0040, n + 16'd15, 13);
    repeat (14) next_cycle();
    bus.dcache_miss = 1'b0;
    #1;
    check("dual_idle_between", 64'(bus.dbg_state), 64'(IDLE));
    check("dual_stall_between", 64'(bus.stall), 64'd1);
    repeat (13) next_cycle();
    check("dual_state_tag", 64'(bus.dbg_state), 64'(TAG));
    next_cycle();
    bus.icache_miss = 1'b0;
    #1 check("dual_idle_end", 64'(bus.dbg_state), 64'(IDLE));

    // store together with a D miss: store first, then fill; stall held
    next_cycle();
    n = cyc;
    bus.store_addr = 16'h2002; bus.store_data = 16'hBEEF; bus.store_req = 1'b1;
    bus.dcache_addr = 16'h3458; bus.dcache_miss = 1'b1;
    exp_q.push_back(ev(K_ST, n + 16'd1, 16'h2002, 16'hBEEF));
    push_fill(1'b1, 16'h3450, n + 16'd3, 13);
    for (int i = 1; i <= 15; i++) begin
      next_cycle();
      if (i == 2) bus.store_req = 1'b0;
      #1;
      check("store_stall_held", 64'(bus.stall), 64'd1);
      if (i == 1)       check("store_state", 64'(bus.dbg_state), 64'(STORE));
      else if (i == 2)  check("store_state", 64'(bus.dbg_state), 64'(IDLE));
      else if (i == 15) check("store_state", 64'(bus.dbg_state), 64'(TAG));
      else              check("store_state", 64'(bus.dbg_state), 64'(FILL));
    end
    next_cycle();
    bus.dcache_miss = 1'b0;
    #1 check("store_idle_end", 64'(bus.dbg_state), 64'(IDLE));

    // reset in FILL cycle 6 of an I fill; held miss refetches the block
    next_cycle();
    n = cyc;
    bus.icache_addr = 16'h4006; bus.icache_miss = 1'b1;
    push_fill(1'b0, 16'h4000, n + 16'd1, 6);
    repeat (7) next_cycle();
    rst = 1'b1;
    #1;
    check("midfill_reset_outputs", outs(), 64'd0);
    check("midfill_reset_state", 64'(bus.dbg_state), 64'(IDLE));
    next_cycle();
    rst = 1'b0;
    push_fill(1'b0, 16'h4000, n + 16'd9, 13);
    repeat (13) next_cycle();
    check("refetch_state_tag", 64'(bus.dbg_state), 64'(TAG));
    next_cycle();
    bus.icache_miss = 1'b0;
    #1 check("refetch_idle", 64'(bus.dbg_state), 64'(IDLE));

    // top-of-memory block, no wrap into 0x0000
    run_fill(1'b1, 16'hFFF8, 16'hFFF0);

    // spurious mem_data_valid in IDLE
    next_cycle();
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("spurious_state", 64'(bus.dbg_state), 64'(IDLE));
      check("spurious_outputs", outs(), 64'd0);
    end
    spurious = 1'b0;

    repeat (3) next_cycle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
